// File: rtl/dm_access_arbiter.sv
// dm_access_arbiter: shares one data-memory port among 4 cores with bounded bursts and a one-cycle arbitration gap.
// Define DM_ARB_FIXED_PRIO_EN for fixed priority (core 1 highest); the default build is round-robin.
module dm_access_arbiter #(
    parameter int unsigned N         = 18,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          req,
    input  logic [3:0]          we,
    input  logic [4*ADDR_W-1:0] addr_in,
    input  logic [4*N-1:0]      wdata_in,
    output logic [3:0]          gnt,
    output logic [3:0]          rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int unsigned NCORE = 4;
    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_e;

    state_e            r_state;
    state_e            w_state_nxt;

    logic [1:0]        r_ptr;
    logic [1:0]        r_owner;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic [3:0]        r_gnt;
    logic [3:0]        r_rvalid;
    logic [DATA_W-1:0] r_rdata;

    logic [ADDR_W-1:0] w_core_addr  [NCORE];
    logic [DATA_W-1:0] w_core_wdata [NCORE];
    logic              w_unused_wdata;

    logic [7:0]        w_req_dbl;
    logic [3:0]        w_req_rot;
    logic [1:0]        w_off;
    logic [1:0]        w_sel;

    logic              w_owner_req;
    logic              w_beat;
    logic              w_last;
    logic              w_release;

    // Split the flat core buses; only the low DATA_W bits of write data reach memory
    always_comb begin
        for (int i = 0; i < NCORE; i++) begin
            w_core_addr[i]  = addr_in[i*ADDR_W +: ADDR_W];
            w_core_wdata[i] = wdata_in[i*N +: DATA_W];
        end
    end

    assign w_unused_wdata = ^wdata_in;

    // First requester at or after the pointer, wrapping modulo 4
    always_comb begin
        w_req_dbl = {req, req};
        w_req_rot = w_req_dbl[{1'b0, r_ptr} +: NCORE];
        w_off     = 2'd0;
        for (int k = NCORE - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_off = 2'(k);
            end
        end
        w_sel = r_ptr + w_off;
    end

    assign w_owner_req = req[r_owner];
    assign w_beat      = (r_state == S_GRANT) && w_owner_req;
    assign w_last      = w_beat && (r_beat_cnt == CNT_W'(MAX_BURST - 1));
    assign w_release   = (r_state == S_GRANT) && (!w_owner_req || w_last);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (|req)     w_state_nxt = S_GRANT;
            S_GRANT: if (w_release) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Memory-side outputs follow the owner's request within the same cycle
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (r_state == S_GRANT) begin
            mem_addr  = w_core_addr[r_owner];
            mem_wdata = w_core_wdata[r_owner];
            if (w_beat) begin
                mem_en = 1'b1;
                mem_we = we[r_owner];
            end
        end
    end

    // Grant, burst counting, pointer rotation and read return
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= 2'd0;
            r_owner    <= 2'd0;
            r_beat_cnt <= '0;
            r_gnt      <= 4'd0;
            r_rvalid   <= 4'd0;
            r_rdata    <= '0;
        end else begin
            r_rvalid <= 4'd0;
            if (|r_rvalid) begin
                r_rdata <= mem_rdata;
            end
            if (w_beat && !we[r_owner]) begin
                r_rvalid <= 4'b0001 << r_owner;
            end
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_owner    <= w_sel;
                        r_gnt      <= 4'b0001 << w_sel;
                        r_beat_cnt <= '0;
                    end
                end
                S_GRANT: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                    end
                    if (w_release) begin
                        r_gnt <= 4'd0;
`ifdef DM_ARB_FIXED_PRIO_EN
                        r_ptr <= 2'd0;
`else
                        r_ptr <= r_owner + 2'd1;
`endif
                    end
                end
                default: r_gnt <= 4'd0;
            endcase
        end
    end

    assign gnt    = r_gnt;
    assign rvalid = r_rvalid;
    // Memory data passes through on the strobe cycle, then the captured copy holds
    assign rdata  = (|r_rvalid) ? mem_rdata : r_rdata;
    assign busy   = (r_state == S_GRANT);

endmodule

// File: tb/tb_dm_access_arbiter.sv
// tb_dm_access_arbiter: scoreboard bench; a transaction-level core/arbiter model predicts grants, memory beats and read returns.
module tb_dm_access_arbiter;

    localparam int unsigned MAXB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  we = '0;
    logic [47:0] addr_in = '0;
    logic [71:0] wdata_in = '0;
    logic [3:0]  gnt;
    logic [3:0]  rvalid;
    logic [11:0] rdata;
    logic        mem_en;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata = '0;
    logic        busy;

    dm_access_arbiter #(.N(18), .ADDR_W(12), .DATA_W(12), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr_in(addr_in), .wdata_in(wdata_in),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory behind the arbiter, plus the bench's own expectation of its contents
    logic [11:0] mem [4096];
    logic [11:0] ref_mem [4096];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    typedef struct { int cyc; int core; } gnt_t;
    typedef struct { int cyc; logic [11:0] addr; logic w; logic [11:0] wd; } beat_t;
    typedef struct { int cyc; int core; logic [11:0] data; } rd_t;
    gnt_t  q_gnt[$];
    beat_t q_beat[$];
    rd_t   q_rd[$];

    // Core-side jobs and arbiter model state
    int          job_rem[4];
    bit          rnd_mode[4];
    logic [11:0] cur_addr[4];
    logic        cur_we[4];
    logic [17:0] cur_wd[4];
    int          m_owner = -1;
    int          m_cnt = 0;
    int          m_ptr = 0;
    logic [3:0]  exp_gnt_now = '0;
    logic        exp_busy_now = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input int c);
        n_checks++;
        n_err++;
        $display("FAIL %s: event mismatch around cycle %0d (now %0d)", name, c, cyc);
    endtask

    task automatic new_beat(input int c);
        if (rnd_mode[c]) begin
            cur_addr[c] = 12'h100 + 12'($urandom_range(0, 15));
            cur_we[c]   = 1'($urandom_range(0, 1));
            cur_wd[c]   = 18'($urandom);
        end
    endtask

    task automatic start_job(input int c, input int len, input logic [11:0] a,
                             input logic w, input logic [17:0] wd, input bit rnd);
        job_rem[c]  = len;
        rnd_mode[c] = rnd;
        cur_addr[c] = a;
        cur_we[c]   = w;
        cur_wd[c]   = wd;
        new_beat(c);
    endtask

    function automatic int pick(input logic [3:0] r);
        int start;
`ifdef DM_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = m_ptr;
`endif
        for (int j = 0; j < 4; j++) begin
            if (r[(start + j) % 4]) return (start + j) % 4;
        end
        return -1;
    endfunction

    // One clock of core behaviour plus the arbiter's expected reaction
    task automatic step(input bit rnd_arrive);
        logic [3:0] r;
        int w;
        @(posedge clk); #1;
        if (rnd_arrive) begin
            for (int i = 0; i < 4; i++)
                if (job_rem[i] == 0 && $urandom_range(0, 5) == 0)
                    start_job(i, $urandom_range(1, 9), 12'h0, 1'b0, 18'h0, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            r[i] = (job_rem[i] > 0);
            we[i] = cur_we[i];
            addr_in[i*12 +: 12] = cur_addr[i];
            wdata_in[i*18 +: 18] = cur_wd[i];
        end
        req = r;
        exp_busy_now = (m_owner >= 0);
        if (m_owner >= 0) exp_gnt_now = 4'b0001 << m_owner;
        else              exp_gnt_now = 4'b0000;

        if (m_owner < 0) begin
            if (r != 4'b0000) begin
                w = pick(r);
                q_gnt.push_back('{cyc + 1, w});
                m_owner = w;
                m_cnt = 0;
            end
        end else if (r[m_owner]) begin
            q_beat.push_back('{cyc, cur_addr[m_owner], cur_we[m_owner], cur_wd[m_owner][11:0]});
            if (cur_we[m_owner]) ref_mem[cur_addr[m_owner]] = cur_wd[m_owner][11:0];
            else q_rd.push_back('{cyc + 1, m_owner, ref_mem[cur_addr[m_owner]]});
            job_rem[m_owner]--;
            new_beat(m_owner);
            m_cnt++;
            if (m_cnt == MAXB) begin
`ifdef DM_ARB_FIXED_PRIO_EN
                m_ptr = 0;
`else
                m_ptr = (m_owner + 1) % 4;
`endif
                m_owner = -1;
            end
        end else begin
`ifdef DM_ARB_FIXED_PRIO_EN
            m_ptr = 0;
`else
            m_ptr = (m_owner + 1) % 4;
`endif
            m_owner = -1;
        end
    endtask

    task automatic run_until_idle(input int limit);
        int n;
        bit done;
        n = 0;
        done = 0;
        while (!done && n < limit) begin
            step(1'b0);
            n++;
            done = (m_owner < 0) && (job_rem[0] == 0) && (job_rem[1] == 0)
                && (job_rem[2] == 0) && (job_rem[3] == 0);
        end
        if (!done) flag("drain_timeout", cyc);
        repeat (3) step(1'b0);
    endtask

    task automatic mid_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        req = 4'b0000;
        for (int i = 0; i < 4; i++) job_rem[i] = 0;
        m_owner = -1;
        m_cnt = 0;
        m_ptr = 0;
        q_rd.delete();
        exp_gnt_now = 4'b0000;
        exp_busy_now = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Monitor: pops expectations whenever the DUT presents grants, beats or returns
    logic [3:0]  prev_gnt = '0;
    logic [11:0] last_rd = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_gnt", 32'(gnt), 32'h0);
            chk("rst_rvalid", 32'(rvalid), 32'h0);
            chk("rst_mem_en", 32'(mem_en), 32'h0);
            chk("rst_mem_we", 32'(mem_we), 32'h0);
            chk("rst_mem_addr", 32'(mem_addr), 32'h0);
            chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
            chk("rst_rdata", 32'(rdata), 32'h0);
            prev_gnt = '0;
            last_rd = '0;
        end else begin
            chk("gnt", 32'(gnt), 32'(exp_gnt_now));
            chk("busy", 32'(busy), 32'(exp_busy_now));

            while (q_gnt.size() > 0 && q_gnt[0].cyc < cyc) begin
                flag("gnt_missing", q_gnt[0].cyc);
                void'(q_gnt.pop_front());
            end
            if (gnt != 4'b0000 && gnt != prev_gnt) begin
                if (q_gnt.size() == 0) flag("gnt_unexpected", cyc);
                else begin
                    gnt_t g;
                    g = q_gnt.pop_front();
                    chk("gnt_owner", 32'(gnt), 32'(4'b0001 << g.core));
                    chk("gnt_cycle", 32'(cyc), 32'(g.cyc));
                end
            end
            prev_gnt = gnt;

            while (q_beat.size() > 0 && q_beat[0].cyc < cyc) begin
                flag("beat_missing", q_beat[0].cyc);
                void'(q_beat.pop_front());
            end
            if (mem_en) begin
                if (q_beat.size() == 0) flag("beat_unexpected", cyc);
                else begin
                    beat_t b;
                    b = q_beat.pop_front();
                    chk("beat_cycle", 32'(cyc), 32'(b.cyc));
                    chk("mem_addr", 32'(mem_addr), 32'(b.addr));
                    chk("mem_we", 32'(mem_we), 32'(b.w));
                    if (b.w) chk("mem_wdata", 32'(mem_wdata), 32'(b.wd));
                end
            end else begin
                chk("mem_we_idle", 32'(mem_we), 32'h0);
            end

            while (q_rd.size() > 0 && q_rd[0].cyc < cyc) begin
                flag("rvalid_missing", q_rd[0].cyc);
                void'(q_rd.pop_front());
            end
            if (rvalid != 4'b0000) begin
                if (q_rd.size() == 0) flag("rvalid_unexpected", cyc);
                else begin
                    rd_t d;
                    d = q_rd.pop_front();
                    chk("rvalid_cycle", 32'(cyc), 32'(d.cyc));
                    chk("rvalid_core", 32'(rvalid), 32'(4'b0001 << d.core));
                    chk("rdata", 32'(rdata), 32'(d.data));
                    last_rd = d.data;
                end
            end else begin
                chk("rdata_hold", 32'(rdata), 32'(last_rd));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = 12'(i * 37 + 5);
            ref_mem[i] = 12'(i * 37 + 5);
        end
        for (int i = 0; i < 4; i++) start_job(i, 0, 12'h0, 1'b0, 18'h0, 1'b0);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single reader: core 1, two reads of 0x008
        start_job(0, 2, 12'h008, 1'b0, 18'h0, 1'b0);
        run_until_idle(50);

        // Burst cap: core 2 holds for eight beats -> two capped tenures
        start_job(1, 8, 12'h010, 1'b0, 18'h0, 1'b0);
        run_until_idle(60);

        // All four cores contend
        for (int i = 0; i < 4; i++) start_job(i, 8, 12'h020 + 12'(i), 1'b0, 18'h0, 1'b0);
        run_until_idle(200);

        // Write path with upper data bits set, then read it back from core 1
        start_job(2, 1, 12'h204, 1'b1, 18'h3_0ABC, 1'b0);
        run_until_idle(30);
        chk("mem_0x204", 32'(mem[12'h204]), 32'h0ABC);
        start_job(0, 1, 12'h204, 1'b0, 18'h0, 1'b0);
        run_until_idle(30);

        // Reset during core 4's second read beat; pointer must restart at core 1
        start_job(1, 1, 12'h030, 1'b0, 18'h0, 1'b0);
        run_until_idle(30);
        start_job(3, 6, 12'h040, 1'b0, 18'h0, 1'b0);
        begin
            int n;
            n = 0;
            while (!(m_owner == 3 && m_cnt == 1) && n < 20) begin
                step(1'b0);
                n++;
            end
            if (n >= 20) flag("core4_burst_timeout", cyc);
        end
        mid_reset();
        start_job(0, 2, 12'h050, 1'b0, 18'h0, 1'b0);
        start_job(3, 2, 12'h060, 1'b0, 18'h0, 1'b0);
        run_until_idle(60);

        // Cores 2 and 4 both hold long requests
        start_job(1, 10, 12'h070, 1'b0, 18'h0, 1'b0);
        start_job(3, 10, 12'h080, 1'b0, 18'h0, 1'b0);
        run_until_idle(120);

        // Random traffic
        repeat (600) step(1'b1);
        run_until_idle(600);

        chk("q_gnt_empty", 32'(q_gnt.size()), 32'h0);
        chk("q_beat_empty", 32'(q_beat.size()), 32'h0);
        chk("q_rd_empty", 32'(q_rd.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
